// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial add sequencer.
// Defines the FSM state encoding and the default width.
package serial_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

  // Bits needed to count 0..w, so w=1 still gets a 1-bit counter.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fa_slice.sv
// One-bit full adder built from two half-adder stages.
// Purely combinational; the sequencer instances it once.
module fa_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic h1_s;
  logic h1_c;
  logic h2_c;

  assign h1_s = a ^ b;
  assign h1_c = a & b;
  assign s    = h1_s ^ cin;
  assign h2_c = h1_s & cin;
  assign cout = h1_c | h2_c;

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add sequencer: one operand bit pair per clock through fa_slice.
// Define SERIAL_ADD_SUB_EN to add the sub port (A-B by two's complement).
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_nx;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             done_valid_q;
  logic             busy_q;
  logic             start_ready_q;
  logic             b_bit;
  logic             fa_s;
  logic             fa_co;
  logic             last;
  logic             init_c;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q;
  assign b_bit  = b_q[0] ^ sub_q;
  assign init_c = sub;
`else
  assign b_bit  = b_q[0];
  assign init_c = 1'b0;
`endif

  fa_slice u_fa (
    .a    (a_q[0]),
    .b    (b_bit),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // New bit enters at the MSB so the LSB-first stream lands in place.
  always_comb begin
    sum_nx = sum_q >> 1;
    sum_nx[WIDTH-1] = fa_s;
  end

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      sum_q         <= '0;
      cnt_q         <= '0;
      carry_q       <= 1'b0;
      cout_q        <= 1'b0;
      done_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      start_ready_q <= 1'b1;
`ifdef SERIAL_ADD_SUB_EN
      sub_q         <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_valid) begin
            a_q           <= op_a;
            b_q           <= op_b;
            sum_q         <= '0;
            cnt_q         <= '0;
            carry_q       <= init_c;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= S_RUN;
`ifdef SERIAL_ADD_SUB_EN
            sub_q         <= sub;
`endif
          end
        end
        S_RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= sum_nx;
          carry_q <= fa_co;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            cout_q       <= fa_co;
            done_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          if (done_ready) begin
            done_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign done_valid  = done_valid_q;
  assign busy        = busy_q;

endmodule
